// File: rtl/liang_pkg.sv
// Shared types and constants for the LSU memory-access controller and its timer.
package liang_pkg;

    localparam int unsigned XLEN                    = 32;
    localparam int unsigned LSU_MEM_TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_mem_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wmask;
    } mem_req_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_mem_timer.sv
// Bus-transaction watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES of 0 disables it.
module lsu_mem_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Expires combinationally in the enabled cycle that brings the count to TIMEOUT_CYCLES.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Blocking LSU memory-access controller: one word-aligned request at a time, driven onto
// a req/gnt/rvalid bus, with a watchdog timeout and discard of late (stale) completions.
module lsu_mem_ctrl
    import liang_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_MEM_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [3:0]      req_wmask_i,

    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    lsu_mem_state_e  state_q, state_d;
    mem_req_t        req_q, req_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic            stale_q, stale_d;

    logic            timer_clear;
    logic            timer_en;
    logic            timer_expired;

    // Byte offset is resolved by the LSU's extraction logic, not here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr_i[1:0];

    assign req_ready_o  = (state_q == StIdle) && !rst_i;
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    // A request is held off the bus while an abandoned transaction may still complete.
    assign mem_req_o   = (state_q == StReq) && !stale_q;
    assign mem_we_o    = req_q.we;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_wmask_o = req_q.wmask;

    assign timer_en = (state_q == StReq) || (state_q == StWait);

    lsu_mem_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        stale_d      = stale_q;
        timer_clear  = 1'b0;

        if (stale_q && mem_rvalid_i) begin
            stale_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_o) begin
                    req_d.we    = req_we_i;
                    req_d.addr  = word_align(req_addr_i);
                    req_d.wdata = req_wdata_i;
                    req_d.wmask = req_wmask_i;
                    timer_clear = 1'b1;
                    if (req_we_i && (req_wmask_i == 4'b0000)) begin
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                        state_d      = StResp;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_req_o && mem_gnt_i) begin
                    if (timer_expired) begin
                        // Granted but out of time: the eventual completion must be dropped.
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                        stale_d      = 1'b1;
                        state_d      = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end else if (timer_expired) begin
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = StResp;
                end
            end
            StWait: begin
                if (mem_rvalid_i && !stale_q) begin
                    resp_rdata_d = (req_q.we || mem_err_i) ? '0 : mem_rdata_i;
                    resp_err_d   = mem_err_i;
                    state_d      = StResp;
                end else if (timer_expired) begin
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    stale_d      = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            req_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            stale_q      <= stale_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed scoreboard bench for lsu_mem_ctrl with an 8-cycle bus timeout.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    lsu_mem_ctrl #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wmask_i  (req_wmask),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wmask_o  (mem_wmask),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .mem_err_i    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err);
        resp_t r;
        r.err   = err;
        r.rdata = rdata;
        sb.push_back(r);
    endtask

    // Called at a negedge with the DUT idle; returns at the next negedge.
    task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask);
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic take_resp(input string tag, input int budget);
        resp_t exp;
        int    waited = 0;
        while (resp_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
        if (resp_valid === 1'b1) begin
            check({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check({tag, "_rdata"}, resp_rdata, exp.rdata);
                check({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp.err});
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            check({tag, "_released"}, {31'b0, resp_valid}, 32'd0);
        end
    endtask

    initial begin
        int waited;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);

        // 1: minimum-latency load from an unaligned address
        push_exp(32'hDEADBEEF, 1'b0);
        accept(1'b0, 32'h8000_0006, 32'h0, 4'h0);
        check("t1_mem_req", {31'b0, mem_req}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h8000_0004);
        check("t1_mem_we", {31'b0, mem_we}, 32'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("t1_wait_no_req", {31'b0, mem_req}, 32'd0);
        check("t1_wait_no_resp", {31'b0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        take_resp("t1", 0);
        check("t1_back_idle", {31'b0, req_ready}, 32'd1);

        // 2: store with a 5-cycle grant delay; request must stay stable
        push_exp(32'h0, 1'b0);
        accept(1'b1, 32'h0000_0100, 32'h0000_AB00, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_req", {31'b0, mem_req}, 32'd1);
            check("t2_hold_addr", mem_addr, 32'h0000_0100);
            check("t2_hold_wdata", mem_wdata, 32'h0000_AB00);
            check("t2_hold_wmask", {28'b0, mem_wmask}, 32'h2);
            check("t2_hold_we", {31'b0, mem_we}, 32'd1);
            @(negedge clk);
        end
        check("t2_req_at_gnt", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        take_resp("t2", 0);

        // 3: empty-mask store completes without touching the bus
        push_exp(32'h0, 1'b0);
        accept(1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'b0000);
        check("t3_no_mem_req", {31'b0, mem_req}, 32'd0);
        take_resp("t3", 0);

        // 4: granted load whose completion never arrives -> timeout after 8 cycles
        push_exp(32'h0, 1'b1);
        accept(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        waited  = 0;
        while (resp_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("t4_timeout_cycles", waited, 32'd7);
        check("t4_req_dropped", {31'b0, mem_req}, 32'd0);
        take_resp("t4", 0);

        // 4b: next request is held off the bus until the late completion is discarded
        push_exp(32'hCAFE_F00D, 1'b0);
        accept(1'b0, 32'h0000_0400, 32'h0, 4'h0);
        check("t4b_blocked0", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("t4b_blocked1", {31'b0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("t4b_stale_dropped", {31'b0, resp_valid}, 32'd0);
        check("t4b_unblocked", {31'b0, mem_req}, 32'd1);
        check("t4b_addr", mem_addr, 32'h0000_0400);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        take_resp("t4b", 0);

        // 5: bus error response held while the LSU stalls
        push_exp(32'h0, 1'b1);
        accept(1'b0, 32'h0000_0500, 32'h0, 4'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_err    = 1'b1;
        mem_rdata  = 32'h0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_valid", {31'b0, resp_valid}, 32'd1);
            check("t5_hold_err", {31'b0, resp_err}, 32'd1);
            check("t5_hold_rdata", resp_rdata, 32'd0);
            check("t5_hold_not_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        take_resp("t5", 0);
        check("t5_ready_after", {31'b0, req_ready}, 32'd1);

        // 6: reset while waiting for a completion aborts without a response
        accept(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("t6_rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("t6_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("t6_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("t6_rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("t6_rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_ready", {31'b0, req_ready}, 32'd1);
        push_exp(32'h0BAD_CAFE, 1'b0);
        accept(1'b0, 32'h0000_0703, 32'h0, 4'h0);
        check("t6_mem_req", {31'b0, mem_req}, 32'd1);
        check("t6_mem_addr", mem_addr, 32'h0000_0700);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_CAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        take_resp("t6", 0);

        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
